// File: rtl/scanchain_writer.sv
`default_nettype none
// ============================================================================
//  Module   : scanchain_writer
//  Purpose  : Accepts one scan-chain write per valid/ready handshake and shifts
//             {payload, addr} LSB first into the chip scan chain.
//  Revision : 1.0 - initial release
// ============================================================================
module scanchain_writer #(
    parameter int ADDR_BITS    = 12,
    parameter int PAYLOAD_BITS = 169,
    parameter int SCAN_CLK_DIV = 4,
    parameter int RESET_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    write_valid,
    output logic                    write_ready,
    input  logic [ADDR_BITS-1:0]    write_addr,
    input  logic [PAYLOAD_BITS-1:0] write_payload,
    input  logic                    write_reset,
    output logic                    scan_clk,
    output logic                    scan_en,
    output logic                    scan_in,
    output logic                    scan_reset,
    output logic                    scan_latch
);

    localparam int c_n       = PAYLOAD_BITS + ADDR_BITS;
    localparam int c_bit_w   = (c_n > 1) ? $clog2(c_n) : 1;
    localparam int c_cnt_max = (SCAN_CLK_DIV > RESET_CYCLES) ? SCAN_CLK_DIV : RESET_CYCLES;
    localparam int c_ph_w    = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(c_n - 1);
    localparam logic [c_ph_w-1:0]  c_div_last = c_ph_w'(SCAN_CLK_DIV - 1);
    localparam logic [c_ph_w-1:0]  c_rst_last = c_ph_w'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_bit_w-1:0]  r_bit, w_bit_nxt;
    logic [c_ph_w-1:0]   r_phase, w_phase_nxt;
    logic                r_high, w_high_nxt;
    logic [c_n-1:0]      r_shift, w_shift_nxt;
    logic                r_ready;
    logic                r_scan_clk, r_scan_en, r_scan_in, r_scan_reset, r_scan_latch;

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_phase_nxt = r_phase;
        w_high_nxt  = r_high;
        w_shift_nxt = r_shift;
        case (r_state)
            ST_IDLE: begin
                if (write_valid && r_ready) begin
                    w_shift_nxt = {write_payload, write_addr};
                    w_state_nxt = write_reset ? ST_RESET : ST_SHIFT;
                    w_bit_nxt   = '0;
                    w_phase_nxt = '0;
                    w_high_nxt  = 1'b0;
                end
            end
            ST_RESET: begin
                if (r_phase == c_rst_last) begin
                    w_state_nxt = ST_SHIFT;
                    w_phase_nxt = '0;
                    w_bit_nxt   = '0;
                    w_high_nxt  = 1'b0;
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (r_phase == c_div_last) begin
                    w_phase_nxt = '0;
                    if (!r_high) begin
                        w_high_nxt = 1'b1;
                    end else if (r_bit == c_last_bit) begin
                        w_state_nxt = ST_LATCH;
                        w_high_nxt  = 1'b0;
                        w_bit_nxt   = '0;
                    end else begin
                        // Next bit: data moves only as the clock returns low
                        w_high_nxt  = 1'b0;
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = r_shift >> 1;
                    end
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end
            ST_LATCH: begin
                if (r_phase == c_div_last) begin
                    w_state_nxt = ST_IDLE;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_bit        <= '0;
            r_phase      <= '0;
            r_high       <= 1'b0;
            r_shift      <= '0;
            r_ready      <= 1'b0;
            r_scan_clk   <= 1'b0;
            r_scan_en    <= 1'b0;
            r_scan_in    <= 1'b0;
            r_scan_reset <= 1'b0;
            r_scan_latch <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit        <= w_bit_nxt;
            r_phase      <= w_phase_nxt;
            r_high       <= w_high_nxt;
            r_shift      <= w_shift_nxt;
            r_ready      <= (w_state_nxt == ST_IDLE);
            r_scan_clk   <= (w_state_nxt == ST_SHIFT) && w_high_nxt;
            r_scan_en    <= (w_state_nxt == ST_SHIFT);
            r_scan_in    <= (w_state_nxt == ST_SHIFT) && w_shift_nxt[0];
            r_scan_reset <= (w_state_nxt == ST_RESET);
            r_scan_latch <= (w_state_nxt == ST_LATCH);
        end
    end

    assign write_ready = r_ready;
    assign scan_clk    = r_scan_clk;
    assign scan_en     = r_scan_en;
    assign scan_in     = r_scan_in;
    assign scan_reset  = r_scan_reset;
    assign scan_latch  = r_scan_latch;

endmodule
`default_nettype wire

// File: tb/tb_scanchain_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scanchain_writer
//  Purpose  : Directed self-checking bench for scanchain_writer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scanchain_writer;

    localparam int c_n = 181;
    localparam logic [168:0] c_payload  = {1'b1, 8'hAD, {5{32'hDEADBEEF}}};
    localparam logic [168:0] c_payload2 = {1'b0, 8'h3C, {5{32'h0F1E2D3C}}};

    logic clk, reset_n;
    logic write_valid, write_ready, write_reset;
    logic [11:0]  write_addr;
    logic [168:0] write_payload;
    logic scan_clk, scan_en, scan_in, scan_reset, scan_latch;

    logic d1_valid, d1_ready, d1_wreset;
    logic [11:0]  d1_addr;
    logic [168:0] d1_payload;
    logic d1_clk, d1_en, d1_in, d1_sreset, d1_latch;

    int tests;
    int fails;

    scanchain_writer #(.ADDR_BITS(12), .PAYLOAD_BITS(169), .SCAN_CLK_DIV(4), .RESET_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n), .write_valid(write_valid), .write_ready(write_ready),
        .write_addr(write_addr), .write_payload(write_payload), .write_reset(write_reset),
        .scan_clk(scan_clk), .scan_en(scan_en), .scan_in(scan_in),
        .scan_reset(scan_reset), .scan_latch(scan_latch)
    );

    scanchain_writer #(.ADDR_BITS(12), .PAYLOAD_BITS(169), .SCAN_CLK_DIV(1), .RESET_CYCLES(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .write_valid(d1_valid), .write_ready(d1_ready),
        .write_addr(d1_addr), .write_payload(d1_payload), .write_reset(d1_wreset),
        .scan_clk(d1_clk), .scan_en(d1_en), .scan_in(d1_in),
        .scan_reset(d1_sreset), .scan_latch(d1_latch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one write on dut and measures the whole busy window
    task automatic run_write(input logic [11:0] a, input logic [168:0] p, input logic f,
                             output int busy, output int rises, output int latch_cyc,
                             output int rst_pre, output int perr,
                             output logic [c_n-1:0] cap, output logic tmo);
        logic pclk, pin, seen_en;
        int n;
        busy = 0; rises = 0; latch_cyc = 0; rst_pre = 0; perr = 0; cap = '0; tmo = 1'b0;
        pclk = 1'b0; pin = 1'b0; seen_en = 1'b0; n = 0;
        @(negedge clk);
        write_addr = a; write_payload = p; write_reset = f; write_valid = 1'b1;
        @(negedge clk);
        write_valid = 1'b0; write_addr = '0; write_payload = '0; write_reset = 1'b0;
        while (!write_ready && n < 3000) begin
            busy++;
            if (scan_clk && !pclk) begin
                if (rises < c_n) cap[rises] = scan_in;
                rises++;
            end
            if (scan_clk && pclk && (scan_in !== pin)) perr++;
            if (scan_clk && !scan_en) perr++;
            if ((int'(scan_en) + int'(scan_reset) + int'(scan_latch)) > 1) perr++;
            if (scan_latch) latch_cyc++;
            if (scan_en) seen_en = 1'b1;
            if (scan_reset) begin
                if (!seen_en) rst_pre++;
                else perr++;
            end
            pclk = scan_clk;
            pin  = scan_in;
            @(negedge clk);
            n++;
        end
        if (n >= 3000) tmo = 1'b1;
    endtask

    task automatic test_reset();
        int bad;
        repeat (3) @(negedge clk);
        tests++;
        if ({write_ready, scan_clk, scan_en, scan_in, scan_reset, scan_latch} !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {write_ready, scan_clk, scan_en, scan_in, scan_reset, scan_latch});
        end
        reset_n = 1'b1;
        #1;
        tests++;
        if (write_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_before_edge: got %b expected 0", write_ready);
        end
        @(negedge clk);
        tests++;
        if (write_ready !== 1'b1 || d1_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_edge: got %b/%b expected 1/1", write_ready, d1_ready);
        end
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if ({scan_clk, scan_en, scan_in, scan_reset, scan_latch} !== 5'b0 || write_ready !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL idle_quiet: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_shift_noreset();
        int busy, rises, latch_cyc, rst_pre, perr;
        logic [c_n-1:0] cap, expf;
        logic tmo;
        expf = {c_payload, 12'hA5C};
        run_write(12'hA5C, c_payload, 1'b0, busy, rises, latch_cyc, rst_pre, perr, cap, tmo);
        tests++;
        if (tmo !== 1'b0) begin fails++; $display("FAIL nr_timeout: got %b expected 0", tmo); end
        tests++;
        if (busy != 1452) begin fails++; $display("FAIL nr_busy: got %0d expected 1452", busy); end
        tests++;
        if (rises != 181) begin fails++; $display("FAIL nr_rises: got %0d expected 181", rises); end
        tests++;
        if (cap !== expf) begin fails++; $display("FAIL nr_bits: got %h expected %h", cap, expf); end
        tests++;
        if (latch_cyc != 4) begin fails++; $display("FAIL nr_latch: got %0d expected 4", latch_cyc); end
        tests++;
        if (rst_pre != 0) begin fails++; $display("FAIL nr_scan_reset: got %0d expected 0", rst_pre); end
        tests++;
        if (perr != 0) begin fails++; $display("FAIL nr_protocol: got %0d expected 0", perr); end
    endtask

    task automatic test_shift_with_reset();
        int busy, rises, latch_cyc, rst_pre, perr;
        logic [c_n-1:0] cap, expf;
        logic tmo;
        expf = {c_payload, 12'hA5C};
        run_write(12'hA5C, c_payload, 1'b1, busy, rises, latch_cyc, rst_pre, perr, cap, tmo);
        tests++;
        if (busy != 1460) begin fails++; $display("FAIL wr_busy: got %0d expected 1460", busy); end
        tests++;
        if (rst_pre != 8) begin fails++; $display("FAIL wr_scan_reset: got %0d expected 8", rst_pre); end
        tests++;
        if (cap !== expf || rises != 181) begin
            fails++;
            $display("FAIL wr_bits: got %h/%0d expected %h/181", cap, rises, expf);
        end
        tests++;
        if (perr != 0 || latch_cyc != 4 || tmo !== 1'b0) begin
            fails++;
            $display("FAIL wr_protocol: got perr=%0d latch=%0d tmo=%b expected 0/4/0", perr, latch_cyc, tmo);
        end
    endtask

    task automatic test_back_to_back();
        int accepts, gaps, busy, latches, rises, n;
        logic pclk, plat;
        @(negedge clk);
        write_addr = 12'h123; write_payload = c_payload; write_reset = 1'b0; write_valid = 1'b1;
        accepts = 1; gaps = 0; busy = 0; latches = 0; rises = 0; n = 0;
        pclk = 1'b0; plat = 1'b0;
        while (n < 6000) begin
            @(negedge clk);
            n++;
            if (write_ready) begin
                if (accepts == 3) break;
                gaps++;
                accepts++;
            end else begin
                busy++;
                if (accepts == 3) write_valid = 1'b0;
            end
            if (scan_clk && !pclk) rises++;
            if (scan_latch && !plat) latches++;
            pclk = scan_clk;
            plat = scan_latch;
        end
        write_valid = 1'b0;
        tests++;
        if (accepts != 3 || gaps != 2) begin
            fails++;
            $display("FAIL b2b_accepts: got %0d accepts %0d gaps expected 3/2", accepts, gaps);
        end
        tests++;
        if (busy != 4356) begin fails++; $display("FAIL b2b_busy: got %0d expected 4356", busy); end
        tests++;
        if (latches != 3 || rises != 543) begin
            fails++;
            $display("FAIL b2b_pulses: got %0d latches %0d rises expected 3/543", latches, rises);
        end
        repeat (5) @(negedge clk);
        tests++;
        if (write_ready !== 1'b1 || scan_en !== 1'b0) begin
            fails++;
            $display("FAIL b2b_no_extra: got ready=%b en=%b expected 1/0", write_ready, scan_en);
        end
    endtask

    task automatic test_abort();
        int rises, n, busy, lat, rst_pre, perr;
        logic pclk, latch_seen, tmo;
        logic [c_n-1:0] cap, expf;
        @(negedge clk);
        write_addr = 12'hFFF; write_payload = c_payload; write_reset = 1'b0; write_valid = 1'b1;
        @(negedge clk);
        write_valid = 1'b0;
        rises = 0; n = 0; pclk = 1'b0; latch_seen = 1'b0;
        while (n < 3000) begin
            if (scan_latch) latch_seen = 1'b1;
            if (scan_clk && !pclk) rises++;
            pclk = scan_clk;
            if (rises == 91) break;
            @(negedge clk);
            n++;
        end
        tests++;
        if (rises != 91 || scan_en !== 1'b1) begin
            fails++;
            $display("FAIL abort_reach_bit90: got rises=%0d en=%b expected 91/1", rises, scan_en);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if ({write_ready, scan_clk, scan_en, scan_in, scan_reset, scan_latch} !== 6'b0) begin
            fails++;
            $display("FAIL abort_outputs: got %b expected 000000",
                     {write_ready, scan_clk, scan_en, scan_in, scan_reset, scan_latch});
        end
        repeat (3) begin
            @(negedge clk);
            if (scan_latch) latch_seen = 1'b1;
        end
        tests++;
        if (latch_seen !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_latch: got %b expected 0", latch_seen);
        end
        // Release with valid already high: the release edge must not accept
        write_valid = 1'b1;
        reset_n = 1'b1;
        @(negedge clk);
        tests++;
        if (write_ready !== 1'b1 || scan_en !== 1'b0) begin
            fails++;
            $display("FAIL release_edge_accept: got ready=%b en=%b expected 1/0", write_ready, scan_en);
        end
        write_valid = 1'b0;
        expf = {c_payload2, 12'h3C1};
        run_write(12'h3C1, c_payload2, 1'b0, busy, rises, lat, rst_pre, perr, cap, tmo);
        tests++;
        if (cap !== expf || rises != 181 || busy != 1452 || lat != 4 || perr != 0) begin
            fails++;
            $display("FAIL abort_fresh_write: got %h r=%0d b=%0d l=%0d p=%0d expected %h r=181 b=1452 l=4 p=0",
                     cap, rises, busy, lat, perr, expf);
        end
    endtask

    task automatic test_div1();
        int busy, rises, lat, togerr, n;
        logic pclk, pen;
        logic [c_n-1:0] cap, expf;
        expf = {{169{1'b1}}, 12'h000};
        busy = 0; rises = 0; lat = 0; togerr = 0; n = 0; cap = '0;
        pclk = 1'b0; pen = 1'b0;
        @(negedge clk);
        d1_addr = '0; d1_payload = '1; d1_wreset = 1'b0; d1_valid = 1'b1;
        @(negedge clk);
        d1_valid = 1'b0; d1_payload = '0;
        while (!d1_ready && n < 1000) begin
            busy++;
            if (d1_clk && !pclk) begin
                if (rises < c_n) cap[rises] = d1_in;
                rises++;
            end
            if (d1_en && pen && (d1_clk === pclk)) togerr++;
            if (d1_latch) lat++;
            pclk = d1_clk;
            pen  = d1_en;
            @(negedge clk);
            n++;
        end
        tests++;
        if (busy != 363) begin fails++; $display("FAIL d1_busy: got %0d expected 363", busy); end
        tests++;
        if (togerr != 0) begin fails++; $display("FAIL d1_toggle: got %0d stalls expected 0", togerr); end
        tests++;
        if (cap !== expf || rises != 181) begin
            fails++;
            $display("FAIL d1_bits: got %h/%0d expected %h/181", cap, rises, expf);
        end
        tests++;
        if (lat != 1) begin fails++; $display("FAIL d1_latch: got %0d expected 1", lat); end
    endtask

    initial begin
        tests = 0; fails = 0;
        reset_n = 1'b0;
        write_valid = 1'b0; write_reset = 1'b0; write_addr = '0; write_payload = '0;
        d1_valid = 1'b0; d1_wreset = 1'b0; d1_addr = '0; d1_payload = '0;
        test_reset();
        test_shift_noreset();
        test_shift_with_reset();
        test_back_to_back();
        test_abort();
        test_div1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
